// File: rtl/clk_div_monitor_if.sv
// Bundle between the divided-clock monitor and its consumers: the divided clock
// going in, plus the edge strobes, period measurement and health flags coming out.
interface clk_div_monitor_if #(
  parameter int PW = 4
);
  logic          div_clk;
  logic          rise_pulse;
  logic          fall_pulse;
  logic [PW-1:0] period;
  logic          period_valid;
  logic          locked;
  logic          stall;
  logic [7:0]    err_count;

  modport master (
    input  div_clk,
    output rise_pulse, fall_pulse, period, period_valid, locked, stall, err_count
  );

  modport slave (
    output div_clk,
    input  rise_pulse, fall_pulse, period, period_valid, locked, stall, err_count
  );
endinterface

// File: rtl/clk_div_monitor.sv
// Samples a divided clock on clk_in, emits rise/fall strobes, measures the
// rise-to-rise period and tracks lock, stall and lock-loss statistics.
module clk_div_monitor #(
  parameter int FACTOR     = 5,
  parameter int LOCK_COUNT = 4,
  parameter int PW         = $clog2(2*FACTOR+1)
) (
  input  logic              clk_in,
  input  logic              rst,
  clk_div_monitor_if.master mon
);

  localparam int            MW        = $clog2(LOCK_COUNT+1);
  localparam logic [PW-1:0] CNT_MAX   = PW'(2*FACTOR);
  localparam logic [PW-1:0] CNT_TO    = PW'(2*FACTOR-1);
  localparam logic [PW-1:0] CNT_EXP   = PW'(FACTOR);
  localparam logic [MW-1:0] MATCH_END = MW'(LOCK_COUNT-1);

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

  state_t        state, state_nxt;
  logic [MW-1:0] match_cnt, match_nxt;
  logic          err_inc;

  logic          s1, s2, s3;
  logic          rise_ev, fall_ev, timeout;
  logic [PW-1:0] cnt;

  logic          rise_q, fall_q, pv_q, locked_q, stall_q;
  logic [PW-1:0] period_q;
  logic [7:0]    err_q;

  assign rise_ev = s2 & ~s3;
  assign fall_ev = ~s2 & s3;
  // Fires only on the step into saturation, so a parked counter cannot retrigger.
  assign timeout = ~rise_ev && (cnt == CNT_TO);

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      match_cnt <= '0;
    end else begin
      // NOTE: state flops use non-blocking assignment so every register samples
      // pre-edge values, independent of process evaluation order.
      state     <= state_nxt;
      match_cnt <= match_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    state_nxt = state;
    match_nxt = match_cnt;
    err_inc   = 1'b0;
    if (rise_ev) begin
      case (state)
        IDLE: begin
          state_nxt = MEASURE;
          match_nxt = '0;
        end
        MEASURE: begin
          if (cnt == CNT_EXP) begin
            if (match_cnt == MATCH_END) begin
              state_nxt = LOCKED;
              match_nxt = '0;
            end else begin
              match_nxt = match_cnt + MW'(1);
            end
          end else begin
            match_nxt = '0;
          end
        end
        LOCKED: begin
          if (cnt != CNT_EXP) begin
            state_nxt = MEASURE;
            match_nxt = '0;
            err_inc   = 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          match_nxt = '0;
        end
      endcase
    end else if (timeout) begin
      state_nxt = IDLE;
      match_nxt = '0;
      err_inc   = (state == LOCKED);
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      cnt      <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      pv_q     <= 1'b0;
      period_q <= '0;
      locked_q <= 1'b0;
      stall_q  <= 1'b0;
      err_q    <= '0;
    end else begin
      s1       <= mon.div_clk;
      s2       <= s1;
      s3       <= s2;
      rise_q   <= rise_ev;
      fall_q   <= fall_ev;
      pv_q     <= 1'b0;
      locked_q <= (state_nxt == LOCKED);

      if (rise_ev) begin
        cnt     <= PW'(1);
        stall_q <= 1'b0;
        // The first rise out of IDLE has no reference edge to measure from.
        if (state != IDLE) begin
          period_q <= cnt;
          pv_q     <= 1'b1;
        end
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + PW'(1);
      end

      if (timeout)
        stall_q <= 1'b1;

      if (err_inc && (err_q != 8'hFF))
        err_q <= err_q + 8'd1;
    end
  end

  assign mon.rise_pulse   = rise_q;
  assign mon.fall_pulse   = fall_q;
  assign mon.period       = period_q;
  assign mon.period_valid = pv_q;
  assign mon.locked       = locked_q;
  assign mon.stall        = stall_q;
  assign mon.err_count    = err_q;

endmodule
